// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit in front of a word-wide data cache
//
// Purpose: accepts one byte/half/word access at a time and turns it into data-cache
// word reads and writes. It performs read-modify-write for sub-word stores and
// lane extraction plus sign or zero extension for loads.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned halves and
// words complete immediately with o_misaligned=1 and make no cache access. When it is
// undefined, the offending low address bits are cleared.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready    request handshake (ready only in IDLE)
//   i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata   request fields
//   o_resp_valid                 one-cycle completion pulse
//   o_resp_rdata, o_misaligned   completion data / flag, held until next completion
//   o_dc_address, o_dc_val, o_dc_op_type   data-cache word address, write word, 0=read 1=write
//   i_dc_val                     data-cache read word (little-endian lanes)
module load_store_unit #(
  parameter int DC_READ_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_misaligned,
  output logic [31:0] o_dc_address,
  output logic [31:0] o_dc_val,
  output logic        o_dc_op_type,
  input  logic [31:0] i_dc_val
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DC_READ_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;        // normalised: 00 byte, 01 half, 10 word
  logic [1:0]  r_off;         // byte lane after any alignment
  logic [15:0] r_wdata;       // only the sub-word part is needed after acceptance
  logic [31:0] r_dc_address;
  logic [31:0] r_dc_val;
  logic [31:0] r_rdata;
  logic        r_misaligned;

  logic        w_accept;
  logic        w_is_word;
  logic        w_is_half;
  logic        w_trap;
  logic        w_rd_done;
  logic [1:0]  w_off;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_merge;

  assign w_accept  = i_req_valid && (r_state == IDLE);
  assign w_is_word = i_req_size[1];
  assign w_is_half = (i_req_size == 2'b01);
  // Lane offset with the offending low bits cleared; a no-op for aligned requests.
  assign w_off     = w_is_word ? 2'b00 : (w_is_half ? {i_req_addr[1], 1'b0} : i_req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_is_half && i_req_addr[0]) || (w_is_word && (i_req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Final RD_WAIT cycle: the cache word is sampled on the edge that ends it.
  assign w_rd_done = (r_state == RD_WAIT) && (r_cnt == 4'd0);

  // Load lane extraction and extension.
  always_comb begin
    w_ld_byte = i_dc_val[7:0];
    case (r_off)
      2'd0: w_ld_byte = i_dc_val[7:0];
      2'd1: w_ld_byte = i_dc_val[15:8];
      2'd2: w_ld_byte = i_dc_val[23:16];
      2'd3: w_ld_byte = i_dc_val[31:24];
    endcase
    w_ld_half = r_off[1] ? i_dc_val[31:16] : i_dc_val[15:0];
    if (r_size[1]) begin
      w_ld_data = i_dc_val;
    end else if (r_size[0]) begin
      w_ld_data = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
    end else begin
      w_ld_data = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
    end
  end

  // Sub-word store: splice the new lanes into the word just read.
  always_comb begin
    w_st_merge = i_dc_val;
    if (r_size[0]) begin
      if (r_off[1]) w_st_merge[31:16] = r_wdata;
      else          w_st_merge[15:0]  = r_wdata;
    end else begin
      case (r_off)
        2'd0: w_st_merge[7:0]   = r_wdata[7:0];
        2'd1: w_st_merge[15:8]  = r_wdata[7:0];
        2'd2: w_st_merge[23:16] = r_wdata[7:0];
        2'd3: w_st_merge[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_dc_op_type = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) begin
          if (w_trap)                     w_next_state = RESP;
          else if (i_req_we && w_is_word) w_next_state = WR;
          else                            w_next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 4'd0) w_next_state = r_we ? WR : RESP;
      end
      WR: begin
        o_dc_op_type = 1'b1;
        w_next_state = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Response fields only change on the edge that enters RESP, so they hold
  // their value from one completion to the next.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_wdata      <= 16'd0;
      r_dc_address <= 32'd0;
      r_dc_val     <= 32'd0;
      r_rdata      <= 32'd0;
      r_misaligned <= 1'b0;
    end else begin
      if ((r_state == RD_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
      if (w_accept) begin
        r_we       <= i_req_we;
        r_unsigned <= i_req_unsigned;
        r_size     <= w_is_word ? 2'b10 : i_req_size;
        r_off      <= w_off;
        r_wdata    <= i_req_wdata[15:0];
        r_cnt      <= CNT_INIT;
        if (w_trap) begin
          r_rdata      <= 32'd0;
          r_misaligned <= 1'b1;
        end else begin
          r_dc_address <= {i_req_addr[31:2], 2'b00};
          if (i_req_we && w_is_word) r_dc_val <= i_req_wdata;
        end
      end
      if (w_rd_done) begin
        if (r_we) begin
          r_dc_val <= w_st_merge;
        end else begin
          r_rdata      <= w_ld_data;
          r_misaligned <= 1'b0;
        end
      end
      if (r_state == WR) begin
        r_rdata      <= 32'd0;
        r_misaligned <= 1'b0;
      end
    end
  end

  assign o_resp_rdata = r_rdata;
  assign o_misaligned = r_misaligned;
  assign o_dc_address = r_dc_address;
  assign o_dc_val     = r_dc_val;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int LAT = 3;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_misaligned;
  logic [31:0] o_dc_address;
  logic [31:0] o_dc_val;
  logic        o_dc_op_type;
  logic [31:0] i_dc_val;

  load_store_unit #(.DC_READ_LAT(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_misaligned(o_misaligned),
    .o_dc_address(o_dc_address), .o_dc_val(o_dc_val), .o_dc_op_type(o_dc_op_type),
    .i_dc_val(i_dc_val)
  );

  always #5 i_clk = ~i_clk;

  // Cache model: combinational read, write on the edge ending a write cycle.
  logic [31:0] mem [0:255];
  int wr_cnt = 0;
  int resp_cnt = 0;
  int acc_cnt = 0;
  assign i_dc_val = mem[o_dc_address[9:2]];
  always @(posedge i_clk) begin
    if (o_dc_op_type) begin
      mem[o_dc_address[9:2]] <= o_dc_val;
      wr_cnt <= wr_cnt + 1;
    end
    if (o_resp_valid) resp_cnt <= resp_cnt + 1;
    if (i_req_valid && o_req_ready) acc_cnt <= acc_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its completion; lat counts edges from the
  // acceptance edge (1) to the edge after which o_resp_valid is seen.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic mis, output int lat);
    int n;
    rdata = 32'd0;
    mis   = 1'b0;
    lat   = -1;
    @(negedge i_clk);
    n = 0;
    while (!o_req_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    n = 1;
    while (n < 40 && lat < 0) begin
      @(posedge i_clk);
      #1;
      n++;
      if (o_resp_valid) begin
        lat   = n;
        rdata = o_resp_rdata;
        mis   = o_misaligned;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          w0, r0, a0, n;
    logic        ready_bad;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          w0, r0, a0, n;
    logic        ready_bad;

    // we size uns addr wdata exp_rdata exp_mis exp_lat exp_mem
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 32'h0,        1'b0, 2,     32'hDEADBEEF});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0, LAT+1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1000, 32'h11223344, 32'h0,        1'b0, 2,     32'h11223344});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h1002, 32'h000000AA, 32'h0,        1'b0, LAT+2, 32'h11AA3344});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h11AA3344, 1'b0, LAT+1, 32'h11AA3344});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1000, 32'h80FF7F01, 32'h0,        1'b0, 2,     32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h1002, 32'h0,        32'hFFFFFFFF, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h1002, 32'h0,        32'h000080FF, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h1000, 32'h0,        32'h00000001, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h1001, 32'h0,        32'h0000007F, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1002, 32'h0,        32'hFFFF80FF, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        32'h00000080, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h1000, 32'h0,        32'h80FF7F01, 1'b0, LAT+1, 32'h80FF7F01});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h1004, 32'hCAFEF00D, 32'h0,        1'b0, 2,     32'hCAFEF00D});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h1006, 32'hFFFF1234, 32'h0,        1'b0, LAT+2, 32'h1234F00D});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1004, 32'h0,        32'hFFFFF00D, 1'b0, LAT+1, 32'h1234F00D});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h1001, 32'h12345655, 32'h0,        1'b0, LAT+2, 32'h80FF5501});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        32'h80FF5501, 1'b0, LAT+1, 32'h80FF5501});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1001, 32'h0,        32'h0,        1'b1, 2,     32'h80FF5501});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1003, 32'h0,        32'h0,        1'b1, 2,     32'h80FF5501});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h1005, 32'h0000BEEF, 32'h0,        1'b1, 2,     32'h1234F00D});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h1004, 32'h0,        32'h0000F00D, 1'b0, LAT+1, 32'h1234F00D});
`else
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h1001, 32'h0,        32'h80FF5501, 1'b0, LAT+1, 32'h80FF5501});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h1003, 32'h0,        32'hFFFF80FF, 1'b0, LAT+1, 32'h80FF5501});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h1005, 32'h0000BEEF, 32'h0,        1'b0, LAT+2, 32'h1234BEEF});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h1004, 32'h0,        32'h0000BEEF, 1'b0, LAT+1, 32'h1234BEEF});
`endif

    i_rst = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0;
    i_req_unsigned = 1'b0; i_req_addr = 32'd0; i_req_wdata = 32'd0;
    repeat (3) @(negedge i_clk);
    chk("reset resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("reset rdata", o_resp_rdata, 32'd0);
    chk("reset dc_address", o_dc_address, 32'd0);
    chk("reset dc_val", o_dc_val, 32'd0);
    chk("reset op_type", {31'd0, o_dc_op_type}, 32'd0);
    chk("reset misaligned", {31'd0, o_misaligned}, 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 chk("ready after reset", {31'd0, o_req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      w0 = wr_cnt;
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, mis, lat);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d misaligned", i), {31'd0, mis}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d mem", i), mem[vecs[i].addr[9:2]], vecs[i].exp_mem);
      chk($sformatf("v%0d writes", i), wr_cnt - w0,
          (vecs[i].we && !vecs[i].exp_mis) ? 32'd1 : 32'd0);
    end

    // Reset while a sub-word store sits in WR: no write, no response.
    do_req(1'b1, 2'd2, 1'b0, 32'h1008, 32'h55667788, rd, mis, lat);
    chk("rst preload mem", mem[2], 32'h55667788);
    @(negedge i_clk);
    n = 0;
    while (!o_req_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = 32'h1008; i_req_wdata = 32'h00000099;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    w0 = wr_cnt;
    r0 = resp_cnt;
    n = 0;
    while (!o_dc_op_type && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("rst reached WR", {31'd0, o_dc_op_type}, 32'd1);
    i_rst = 1'b0;
    #1;
    chk("rst op_type", {31'd0, o_dc_op_type}, 32'd0);
    chk("rst resp_valid", {31'd0, o_resp_valid}, 32'd0);
    chk("rst rdata", o_resp_rdata, 32'd0);
    chk("rst misaligned", {31'd0, o_misaligned}, 32'd0);
    chk("rst dc_address", o_dc_address, 32'd0);
    chk("rst dc_val", o_dc_val, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst ready after release", {31'd0, o_req_ready}, 32'd1);
    chk("rst no write", wr_cnt - w0, 32'd0);
    chk("rst no response", resp_cnt - r0, 32'd0);
    chk("rst mem intact", mem[2], 32'h55667788);
    do_req(1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, rd, mis, lat);
    chk("rst reload", rd, 32'h55667788);

    // i_req_valid held high across two loads.
    @(negedge i_clk);
    n = 0;
    while (!o_req_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    a0 = acc_cnt;
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0;
    i_req_addr = 32'h1000; i_req_wdata = 32'h0;
    @(posedge i_clk);
    #1;
    ready_bad = 1'b0;
    n = 1;
    while (!o_resp_valid && n < 40) begin
      if (o_req_ready) ready_bad = 1'b1;
      @(posedge i_clk);
      #1;
      n++;
    end
    if (o_req_ready) ready_bad = 1'b1;
    chk("b2b ready low in first", {31'd0, ready_bad}, 32'd0);
    chk("b2b first latency", n, LAT + 1);
    chk("b2b first rdata", o_resp_rdata, 32'h80FF5501);
    chk("b2b one accept", acc_cnt - a0, 32'd1);
    @(posedge i_clk);
    #1;
    chk("b2b idle gap ready", {31'd0, o_req_ready}, 32'd1);
    chk("b2b idle gap no resp", {31'd0, o_resp_valid}, 32'd0);
    i_req_addr = 32'h1004;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    chk("b2b second accept", acc_cnt - a0, 32'd2);
    n = 1;
    while (!o_resp_valid && n < 40) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("b2b second latency", n, LAT + 1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("b2b second rdata", o_resp_rdata, 32'h1234F00D);
`else
    chk("b2b second rdata", o_resp_rdata, 32'h1234BEEF);
`endif
    repeat (2) @(posedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
